skein_round_engine: RTL and testbench
=====================================

SKEIN_ROUND_ENGINE -- requirements
Module: skein_round_engine

Interface
REQ-001 SHALL have parameter NW, default 4: state words per block; legal values 4 (Threefish-256) and 8 (Threefish-512).
REQ-002 SHALL have parameter NR, default 4: rounds per job; legal range 1..255.
REQ-003 SHALL have ports: clk  in  1  sole clock; one clock, all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  job offered.
REQ-006 in_ready  out  1  engine can accept a job.
REQ-007 in_dec  in  1  0 = forward rounds, 1 = inverse rounds.
REQ-008 in_rnd  in  3  round index d (mod 8) of the first round applied.
REQ-009 in_state  in  64*NW  word i at bits [64i+63:64i].
REQ-010 out_valid  out  1  result held.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 out_state  out  64*NW  result, same word order as in_state.
REQ-013 busy  out  1  high in RUN or DONE.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 Accept = in_valid & in_ready: latch in_state, in_dec and in_rnd; clear the round counter k; go to RUN.
REQ-016 RUN SHALL apply exactly one round per clock; k runs 0..NR-1; after the round with k = NR-1, go to DONE.
REQ-017 out_valid SHALL rise exactly NR cycles after the accept edge.
REQ-018 Round index: forward d = (in_rnd + k) mod 8; inverse d = (in_rnd - k) mod 8; wrap-around is modulo 8.
REQ-019 Forward round SHALL apply MIX j to words (2j, 2j+1), for j = 0..NW/2-1: y0 = x0 + x1 mod 2^64; y1 = rotl(x1, R[d][j]) ^ y0. It SHALL then permute: new[i] = old[P[i]].
REQ-020 Inverse round SHALL first unpermute: new[P[i]] = old[i]. It SHALL then apply inverse MIX: x1 = rotr(y1 ^ y0, R[d][j]); x0 = y0 - x1 mod 2^64.
REQ-021 Rotation constants R[d][j], NW=4, d0..d7: (14,16), (52,57), (23,40), (5,37), (25,33), (46,12), (58,22), (32,32).
REQ-022 Rotation constants R[d][j], NW=8:
- d0: 46,36,19,37
- d1: 33,27,14,42
- d2: 17,49,36,39
- d3: 44,9,54,56
- d4: 39,30,34,24
- d5: 13,50,10,17
- d6: 25,29,39,43
- d7: 8,35,56,22
REQ-023 Permutation P: NW=4 is (0,3,2,1); NW=8 is (2,1,4,7,6,5,0,3).
REQ-024 In DONE, out_state SHALL stay stable while out_ready=0; on out_ready=1 go to IDLE. in_ready rises the following cycle; there is no same-cycle re-accept.
REQ-025 in_valid and all input buses SHALL be ignored outside IDLE.
REQ-026 out_state SHALL be driven from the state register at all times; it is meaningful only while out_valid=1.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, k=0, state register=0. Outputs then read in_ready=1, out_valid=0, busy=0, out_state=0.
REQ-028 rst during RUN or DONE SHALL abort the job with no output; rst has priority over every other transition.

Structure
REQ-029 Package skein_pkg SHALL hold the R tables for NW=4 and NW=8, the P tables, the FSM state encoding, and the word width constant (64).
REQ-030 Sub-module skein_mix_unit SHALL be combinational with ports x0, x1, 6-bit rotation amount, and dec. It computes forward or inverse MIX and is instantiated NW/2 times.
REQ-031 The round datapath SHALL be single-cycle with no pipelining; the only registers are the state, k, d and the FSM.

Verification
REQ-032 NW=4, NR=1, fwd, in_rnd=0, words (0,1,0,1) -> out_valid 1 cycle after accept; words (0x1, 0x10001, 0x1, 0x4001).
REQ-033 Round-trip: NW=4 and NW=8, NR=8, fwd in_rnd=0 on a random vector; then inv in_rnd=7 on the result -> original vector restored bit-exact.
REQ-034 All-zero in_state, any mode/NW/NR -> all-zero out_state after NR cycles.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_state constant, in_ready=0, busy=1; release -> IDLE next cycle.
REQ-036 Assert rst during cycle 2 of an NR=4 job -> next cycle in_ready=1, out_valid=0; a new job then completes correctly.
REQ-037 NW=8, NR=72, fwd, in_rnd=5 (wrap-around), random vectors -> matches a software Threefish-512 round model without subkey injection.

Source files
------------

// File: rtl/skein_pkg.sv
// rtl/skein_pkg.sv - Threefish round constants, permutations and FSM encoding
package skein_pkg;

    localparam int WORD_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    localparam logic [5:0] ROT4 [8][2] = '{
        '{6'd14, 6'd16}, '{6'd52, 6'd57}, '{6'd23, 6'd40}, '{6'd5,  6'd37},
        '{6'd25, 6'd33}, '{6'd46, 6'd12}, '{6'd58, 6'd22}, '{6'd32, 6'd32}
    };

    localparam logic [5:0] ROT8 [8][4] = '{
        '{6'd46, 6'd36, 6'd19, 6'd37},
        '{6'd33, 6'd27, 6'd14, 6'd42},
        '{6'd17, 6'd49, 6'd36, 6'd39},
        '{6'd44, 6'd9,  6'd54, 6'd56},
        '{6'd39, 6'd30, 6'd34, 6'd24},
        '{6'd13, 6'd50, 6'd10, 6'd17},
        '{6'd25, 6'd29, 6'd39, 6'd43},
        '{6'd8,  6'd35, 6'd56, 6'd22}
    };

    localparam int PERM4 [4] = '{0, 3, 2, 1};
    localparam int PERM8 [8] = '{2, 1, 4, 7, 6, 5, 0, 3};

    // Masked indices keep the unused table branch in range at elaboration.
    function automatic int perm(input int nw, input int i);
        return (nw == 8) ? PERM8[i & 7] : PERM4[i & 3];
    endfunction

    function automatic logic [5:0] rot_amt(input int nw, input logic [2:0] d, input int j);
        return (nw == 8) ? ROT8[d][j & 3] : ROT4[d][j & 1];
    endfunction

endpackage

// File: rtl/skein_mix_unit.sv
// rtl/skein_mix_unit.sv - combinational Threefish MIX and inverse MIX
module skein_mix_unit
    import skein_pkg::*;
(
    input  logic [WORD_W-1:0] x0,
    input  logic [WORD_W-1:0] x1,
    input  logic [5:0]        rot,
    input  logic              dec,
    output logic [WORD_W-1:0] y0,
    output logic [WORD_W-1:0] y1
);

    logic [WORD_W-1:0]   fwd_sum;
    logic [WORD_W-1:0]   inv_xor;
    logic [2*WORD_W-1:0] rotl_dbl;
    logic [2*WORD_W-1:0] rotr_dbl;

    // Rotations as shifts of a doubled word, so rot=0 needs no special case.
    assign fwd_sum  = x0 + x1;
    assign rotl_dbl = {x1, x1} << rot;
    assign inv_xor  = x1 ^ x0;
    assign rotr_dbl = {inv_xor, inv_xor} >> rot;

    always_comb begin
        y0 = fwd_sum;
        y1 = rotl_dbl[2*WORD_W-1:WORD_W] ^ fwd_sum;
        if (dec) begin
            y1 = rotr_dbl[WORD_W-1:0];
            y0 = x0 - rotr_dbl[WORD_W-1:0];
        end
    end

endmodule

// File: rtl/skein_round_engine.sv
// rtl/skein_round_engine.sv - iterative Threefish round engine, one round per clock
module skein_round_engine
    import skein_pkg::*;
#(
    parameter int NW = 4,
    parameter int NR = 4
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_dec,
    input  logic [2:0]         in_rnd,
    input  logic [64*NW-1:0]   in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [64*NW-1:0]   out_state,
    output logic               busy
);

    fsm_t              state, state_nxt;
    logic [7:0]        k;
    logic [2:0]        d;
    logic              dec;
    logic              last_round;

    logic [WORD_W-1:0] words  [NW];
    logic [WORD_W-1:0] unperm [NW];
    logic [WORD_W-1:0] mixed  [NW];
    logic [WORD_W-1:0] next_w [NW];

    assign in_ready   = (state == ST_IDLE);
    assign out_valid  = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);
    assign last_round = (k == 8'(NR - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)   state_nxt = ST_RUN;
            ST_RUN:  if (last_round) state_nxt = ST_DONE;
            ST_DONE: if (out_ready)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NW; i++) words[i] <= '0;
            k   <= '0;
            d   <= '0;
            dec <= 1'b0;
        end else if (state == ST_IDLE && in_valid) begin
            for (int i = 0; i < NW; i++) words[i] <= in_state[64*i +: 64];
            k   <= '0;
            d   <= in_rnd;
            dec <= in_dec;
        end else if (state == ST_RUN) begin
            for (int i = 0; i < NW; i++) words[i] <= next_w[i];
            k   <= k + 8'd1;
            d   <= dec ? d - 3'd1 : d + 3'd1;
        end
    end

    // Forward rounds mix then permute; inverse rounds unpermute then unmix.
    for (genvar i = 0; i < NW; i++) begin : g_perm
        localparam int PI = perm(NW, i);
        assign unperm[PI]  = words[i];
        assign next_w[i]   = dec ? mixed[i] : mixed[PI];
        assign out_state[64*i +: 64] = words[i];
    end

    for (genvar j = 0; j < NW/2; j++) begin : g_mix
        skein_mix_unit u_mix (
            .x0  (dec ? unperm[2*j]   : words[2*j]),
            .x1  (dec ? unperm[2*j+1] : words[2*j+1]),
            .rot (rot_amt(NW, d, j)),
            .dec (dec),
            .y0  (mixed[2*j]),
            .y1  (mixed[2*j+1])
        );
    end

endmodule

// File: tb/tb_skein_round_engine.sv
// tb/tb_skein_round_engine.sv - randomized self-checking bench against a Threefish round model
module tb_skein_round_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [4:0]   vld = '0;
    logic         in_dec = 1'b0;
    logic [2:0]   in_rnd = '0;
    logic [511:0] in_st = '0;
    logic         out_ready = 1'b1;
    logic [4:0]   ir, ov, bz;
    logic [255:0] os_a, os_b, os_e;
    logic [511:0] os_c, os_d;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    int rc4 [8][2] = '{'{14,16},'{52,57},'{23,40},'{5,37},'{25,33},'{46,12},'{58,22},'{32,32}};
    int rc8 [8][4] = '{'{46,36,19,37},'{33,27,14,42},'{17,49,36,39},'{44,9,54,56},
                       '{39,30,34,24},'{13,50,10,17},'{25,29,39,43},'{8,35,56,22}};
    int p4 [4] = '{0,3,2,1};
    int p8 [8] = '{2,1,4,7,6,5,0,3};
    int nw_of [5] = '{4,4,8,8,4};
    int nr_of [5] = '{1,8,8,72,4};

    skein_round_engine #(.NW(4), .NR(1)) u_a (.clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(ir[0]),
        .in_dec(in_dec), .in_rnd(in_rnd), .in_state(in_st[255:0]), .out_valid(ov[0]),
        .out_ready(out_ready), .out_state(os_a), .busy(bz[0]));
    skein_round_engine #(.NW(4), .NR(8)) u_b (.clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(ir[1]),
        .in_dec(in_dec), .in_rnd(in_rnd), .in_state(in_st[255:0]), .out_valid(ov[1]),
        .out_ready(out_ready), .out_state(os_b), .busy(bz[1]));
    skein_round_engine #(.NW(8), .NR(8)) u_c (.clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(ir[2]),
        .in_dec(in_dec), .in_rnd(in_rnd), .in_state(in_st), .out_valid(ov[2]),
        .out_ready(out_ready), .out_state(os_c), .busy(bz[2]));
    skein_round_engine #(.NW(8), .NR(72)) u_d (.clk(clk), .rst(rst), .in_valid(vld[3]), .in_ready(ir[3]),
        .in_dec(in_dec), .in_rnd(in_rnd), .in_state(in_st), .out_valid(ov[3]),
        .out_ready(out_ready), .out_state(os_d), .busy(bz[3]));
    skein_round_engine #(.NW(4), .NR(4)) u_e (.clk(clk), .rst(rst), .in_valid(vld[4]), .in_ready(ir[4]),
        .in_dec(in_dec), .in_rnd(in_rnd), .in_state(in_st[255:0]), .out_valid(ov[4]),
        .out_ready(out_ready), .out_state(os_e), .busy(bz[4]));

    function automatic logic [511:0] os_of(input int w);
        case (w)
            0: return {256'b0, os_a};
            1: return {256'b0, os_b};
            2: return os_c;
            3: return os_d;
            default: return {256'b0, os_e};
        endcase
    endfunction

    function automatic logic [63:0] rol(input logic [63:0] x, input int r);
        return (x << r) | (x >> (64 - r));
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] x, input int r);
        return (x >> r) | (x << (64 - r));
    endfunction

    // Whole-job reference: Threefish rounds without key injection.
    function automatic logic [511:0] ref_model(input int nw, input int nr, input bit dec,
                                               input int rnd, input logic [511:0] s);
        logic [63:0] w [8];
        logic [63:0] t [8];
        logic [511:0] res = '0;
        int d, r, p;
        for (int i = 0; i < 8; i++) begin w[i] = s[64*i +: 64]; t[i] = '0; end
        for (int k = 0; k < nr; k++) begin
            d = dec ? (((rnd - k) % 8) + 8) % 8 : (rnd + k) % 8;
            if (!dec) begin
                for (int j = 0; j < nw/2; j++) begin
                    r = (nw == 8) ? rc8[d][j] : rc4[d][j];
                    t[2*j]   = w[2*j] + w[2*j+1];
                    t[2*j+1] = rol(w[2*j+1], r) ^ t[2*j];
                end
                for (int i = 0; i < nw; i++) begin
                    p = (nw == 8) ? p8[i] : p4[i];
                    w[i] = t[p];
                end
            end else begin
                for (int i = 0; i < nw; i++) begin
                    p = (nw == 8) ? p8[i] : p4[i];
                    t[p] = w[i];
                end
                for (int j = 0; j < nw/2; j++) begin
                    r = (nw == 8) ? rc8[d][j] : rc4[d][j];
                    w[2*j+1] = ror(t[2*j+1] ^ t[2*j], r);
                    w[2*j]   = t[2*j] - w[2*j+1];
                end
            end
        end
        for (int i = 0; i < nw; i++) res[64*i +: 64] = w[i];
        return res;
    endfunction

    function automatic logic [511:0] rnd_vec(input int nw);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        if (nw == 4) v[511:256] = '0;
        return v;
    endfunction

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_job(input int w, input bit dec, input int rnd, input logic [511:0] s);
        @(negedge clk);
        in_dec = dec;
        in_rnd = 3'(rnd);
        in_st  = s;
        vld[w] = 1'b1;
        @(posedge clk);
        #1;
        vld[w] = 1'b0;
        in_st  = rnd_vec(8);
        in_dec = ~dec;
    endtask

    task automatic wait_done(input int w, output logic [511:0] res, output int lat);
        lat = 0;
        @(negedge clk);
        while (!ov[w] && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (!ov[w]) check("done_timeout", 512'(ov[w]), 512'd1);
        res = os_of(w);
    endtask

    task automatic run_job(input int w, input bit dec, input int rnd, input logic [511:0] s,
                           output logic [511:0] res, output int lat);
        start_job(w, dec, rnd, s);
        wait_done(w, res, lat);
        @(posedge clk);
        #1;
    endtask

    logic [511:0] v, r1, r2, held;
    int lat;
    bit dm;
    int rn;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", 512'(ir), 512'h1f);
        check("rst_out_valid", 512'(ov), 512'h0);
        check("rst_busy", 512'(bz), 512'h0);
        check("rst_state_c", os_c, '0);
        rst = 1'b0;

        // Known single-round vector, NW=4 NR=1.
        v = {64'd1, 64'd0, 64'd1, 64'd0};
        run_job(0, 1'b0, 0, v, r1, lat);
        check("nr1_latency", 512'(lat), 512'd1);
        check("nr1_value", r1, {256'b0, 64'h4001, 64'h1, 64'h10001, 64'h1});

        // Round trips for both widths.
        for (int w = 1; w <= 2; w++) begin
            v = rnd_vec(nw_of[w]);
            run_job(w, 1'b0, 0, v, r1, lat);
            check("rt_latency", 512'(lat), 512'd8);
            check("rt_fwd", r1, ref_model(nw_of[w], 8, 1'b0, 0, v));
            run_job(w, 1'b1, 7, r1, r2, lat);
            check("rt_restore", r2, v);
        end

        // All-zero input stays zero in every mode.
        for (int w = 0; w < 5; w++) begin
            run_job(w, w[0], w + 3, '0, r1, lat);
            check("zero_in", r1, '0);
            check("zero_latency", 512'(lat), 512'(nr_of[w]));
        end

        // Long Threefish-512 jobs wrapping the round index.
        for (int n = 0; n < 3; n++) begin
            v = rnd_vec(8);
            run_job(3, 1'b0, 5, v, r1, lat);
            check("tf512_nr72", r1, ref_model(8, 72, 1'b0, 5, v));
        end

        // Random mode/index/data on every instance.
        for (int n = 0; n < 20; n++) begin
            for (int w = 0; w < 5; w++) begin
                if (w == 3 && n > 3) continue;
                dm = 1'($urandom_range(0, 1));
                rn = $urandom_range(0, 7);
                v  = rnd_vec(nw_of[w]);
                run_job(w, dm, rn, v, r1, lat);
                check("rand_job", r1, ref_model(nw_of[w], nr_of[w], dm, rn, v));
            end
        end

        // Backpressure on the NR=4 engine.
        out_ready = 1'b0;
        v = rnd_vec(4);
        start_job(4, 1'b0, 2, v);
        wait_done(4, held, lat);
        check("bp_value", held, ref_model(4, 4, 1'b0, 2, v));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_stable", os_of(4), held);
            check("bp_in_ready", 512'(ir[4]), 512'd0);
            check("bp_busy", 512'(bz[4]), 512'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 512'(ir[4]), 512'd1);

        // Reset in the second cycle of a job aborts it.
        start_job(4, 1'b1, 6, rnd_vec(4));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 512'(ir[4]), 512'd1);
        check("abort_out_valid", 512'(ov[4]), 512'd0);
        check("abort_state", os_of(4), '0);
        v = rnd_vec(4);
        run_job(4, 1'b0, 1, v, r1, lat);
        check("after_abort", r1, ref_model(4, 4, 1'b0, 1, v));
        check("after_abort_lat", 512'(lat), 512'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
